// File: rtl/scan_chain_loader_pkg.sv
// scan_pkg: shared types and width helpers for the scan chain loader.
//   state_e       - loader FSM states
//   clog2()       - ceil(log2(n)), usable in constant expressions
//   *_DEF         - default chain length / word width and their derived widths
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int CHAIN_LEN_DEF = 64;
  localparam int W_DEF         = 32;
  localparam int BW_DEF        = clog2(CHAIN_LEN_DEF + 1);
  localparam int IW_DEF        = clog2(W_DEF + 1);

endpackage

// File: rtl/scan_chain_loader_rb_packer.sv
// scan_rb_packer: readback collector plus output register.
//   clk_i, rst_i     - clock, synchronous active-high reset
//   sample_i, bit_i  - shift-cycle strobe and the chain-end bit sampled with it
//   last_i           - this sample is the final bit of the session
//   out_data_o/out_valid_o/out_ready_i - readback word stream
//   blocked_o        - collector full and unable to hand over; stalls shifting
//   idle_o           - collector holds no bits
module scan_rb_packer
  import scan_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sample_i,
  input  logic         bit_i,
  input  logic         last_i,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  output logic         blocked_o,
  output logic         idle_o
);

  localparam int IW = clog2(W + 1);

  logic [W-1:0]  coll_q, coll_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [W-1:0]  out_q, out_d;
  logic          vld_q, vld_d;

  logic          full, xfer;
  logic [W-1:0]  base_coll;
  logic [IW-1:0] base_cnt;

  // A final partial word counts as full; its upper bits stay zero.
  assign full      = (cnt_q == IW'(W)) || last_q;
  assign xfer      = full && (!vld_q || out_ready_i);
  assign blocked_o = full && !xfer;
  assign idle_o    = (cnt_q == '0);

  assign out_data_o  = out_q;
  assign out_valid_o = vld_q;

  always_comb begin
    // On a transfer the collector empties and may take a new bit in the same cycle.
    base_coll = xfer ? '0 : coll_q;
    base_cnt  = xfer ? '0 : cnt_q;
    coll_d    = base_coll;
    cnt_d     = base_cnt;
    last_d    = xfer ? 1'b0 : last_q;
    if (sample_i) begin
      for (int i = 0; i < W; i++) begin
        if (IW'(i) == base_cnt) coll_d[i] = bit_i;
      end
      cnt_d = base_cnt + IW'(1);
      if (last_i) last_d = 1'b1;
    end

    out_d = out_q;
    vld_d = vld_q;
    if (xfer) begin
      out_d = coll_q;
      vld_d = 1'b1;
    end else if (vld_q && out_ready_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coll_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
      out_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      coll_q <= coll_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// scan_chain_loader: serialises load words onto a scff chain and collects
// the bits falling out of the chain end into readback words.
//   clk, R                       - clock, synchronous active-high reset
//   start                        - begin a session (IDLE only)
//   in_data/in_valid/in_ready    - load word stream, LSB shifted first
//   scan_si, scan_en, scan_clk_en, scan_so - chain interface
//   out_data/out_valid/out_ready - readback word stream, LSB = first bit out
//   busy, done                   - session status, done is a one-cycle pulse
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | loading words and shifting CHAIN_LEN bits
// ST_FLUSH | waiting for the final readback word to be consumed
// ST_DONE  | one-cycle end-of-session pulse
module scan_chain_loader
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int W         = W_DEF
) (
  input  logic         clk,
  input  logic         R,
  input  logic         start,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         scan_si,
  output logic         scan_en,
  output logic         scan_clk_en,
  input  logic         scan_so,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int BW = clog2(CHAIN_LEN + 1);
  localparam int IW = clog2(W + 1);
  localparam logic [BW-1:0] LEN_C    = BW'(CHAIN_LEN);
  localparam logic [BW-1:0] LAST_IDX = BW'(CHAIN_LEN - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-1:0]  load_q, load_d;
  logic [IW-1:0] load_cnt_q, load_cnt_d;
  logic          si_q, si_d;

  logic          rb_blocked, rb_idle;
  logic          in_hs, shift_en, last_shift;
  logic [BW-1:0] bits_left;

  // Every loaded bit has been shifted once the load register is empty,
  // so bit_cnt_q doubles as the count of bits already loaded.
  assign in_ready   = (state_q == ST_SHIFT) && (load_cnt_q == '0) && (bit_cnt_q != LEN_C);
  assign in_hs      = in_valid && in_ready;
  assign shift_en   = (state_q == ST_SHIFT) && (load_cnt_q != '0) && !rb_blocked;
  assign last_shift = shift_en && (bit_cnt_q == LAST_IDX);
  assign bits_left  = LEN_C - bit_cnt_q;

  assign scan_si     = shift_en ? load_q[0] : si_q;
  assign scan_clk_en = shift_en;
  assign scan_en     = (state_q == ST_SHIFT) || (state_q == ST_FLUSH);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    load_d     = load_q;
    load_cnt_d = load_cnt_q;
    si_d       = si_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = '0;
          load_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (in_hs) begin
          load_d = in_data;
          // The final word only contributes the bits the chain still needs.
          if (int'(bits_left) < W) load_cnt_d = IW'(bits_left);
          else                     load_cnt_d = IW'(W);
        end else if (shift_en) begin
          si_d       = load_q[0];
          load_d     = load_q >> 1;
          load_cnt_d = load_cnt_q - IW'(1);
          bit_cnt_d  = bit_cnt_q + BW'(1);
          if (last_shift) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (rb_idle && out_valid && out_ready) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      load_q     <= '0;
      load_cnt_q <= '0;
      si_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      load_q     <= load_d;
      load_cnt_q <= load_cnt_d;
      si_q       <= si_d;
    end
  end

  scan_rb_packer #(.W(W)) u_rb_packer (
    .clk_i       (clk),
    .rst_i       (R),
    .sample_i    (shift_en),
    .bit_i       (scan_so),
    .last_i      (last_shift),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .blocked_o   (rb_blocked),
    .idle_o      (rb_idle)
  );

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: a behavioural scff chain driven by scan_si /
// scan_clk_en, directed and randomised sessions, plus a 1-cell, 1-bit instance.
module tb_scan_chain_loader;

  localparam int CL = 10;
  localparam int W  = 4;
  localparam int NW = (CL + W - 1) / W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         R = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1, scan_so = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, scan_si, scan_en, scan_clk_en, out_valid, busy, done;
  logic [W-1:0] out_data;

  scan_chain_loader #(.CHAIN_LEN(CL), .W(W)) dut (
    .clk(clk), .R(R), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .scan_si(scan_si), .scan_en(scan_en),
    .scan_clk_en(scan_clk_en), .scan_so(scan_so), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  logic       start2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b1, so2 = 1'b0;
  logic [0:0] in_data2 = '0;
  logic       in_ready2, scan_si2, scan_en2, scan_clk_en2, out_valid2, busy2, done2;
  logic [0:0] out_data2;

  scan_chain_loader #(.CHAIN_LEN(1), .W(1)) dut2 (
    .clk(clk), .R(R), .start(start2), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .scan_si(scan_si2), .scan_en(scan_en2),
    .scan_clk_en(scan_clk_en2), .scan_so(so2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2), .done(done2)
  );

  int checks = 0;
  int errors = 0;
  int sess   = 0;

  // Chain model: bit 0 is the last cell (next bit out on scan_so).
  logic [CL-1:0] chain;
  logic [W-1:0]  words [NW];

  int            t;
  int            hs_t[$];
  int            sh_t[$];
  logic [W-1:0]  rb_q[$];
  logic [CL-1:0] shifted;
  int            nsh, done_t, done_cnt, en_bad, last_rb_t;
  logic          prev_si, prev_done, post_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s session=%0d observed=%0h expected=%0h", tag, sess, obs, exp);
    end
  endtask

  task automatic cycle();
    logic sh, si;
    @(negedge clk);
    sh = scan_clk_en;
    si = scan_si;
    if (in_valid && in_ready) hs_t.push_back(t);
    if (sh) begin
      sh_t.push_back(t);
      if (nsh < CL) shifted[nsh] = si;
      nsh++;
    end
    if (out_valid && out_ready) begin
      rb_q.push_back(out_data);
      last_rb_t = t;
    end
    if (prev_done) post_busy = busy;
    prev_done = done;
    if (done) begin
      done_cnt++;
      done_t = t;
    end
    if (busy && !done && !scan_en) en_bad++;
    if ((!busy || done) && scan_en) en_bad++;
    if (sh && !busy) en_bad++;
    if (!sh && scan_si !== prev_si) en_bad++;
    if (sh) prev_si = si;
    @(posedge clk);
    #1;
    if (sh) chain = {si, chain[CL-1:1]};
    scan_so = chain[0];
    t++;
  endtask

  function automatic logic [CL-1:0] exp_load();
    logic [CL-1:0] v;
    logic [W-1:0]  wv;
    for (int b = 0; b < CL; b++) begin
      wv   = words[b / W];
      v[b] = wv[b % W];
    end
    return v;
  endfunction

  function automatic logic [W-1:0] exp_rb(input logic [CL-1:0] init, input int k);
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < W; j++) if (k * W + j < CL) v[j] = init[k * W + j];
    return v;
  endfunction

  task automatic run_session(input int gap, input int slo, input int shi, input int rst_at,
                             output logic [CL-1:0] init);
    int widx, gcnt, hsb;
    bit fin;
    init = chain;
    hs_t.delete(); sh_t.delete(); rb_q.delete();
    shifted = '0; nsh = 0; done_t = -1; done_cnt = 0; en_bad = 0; last_rb_t = -1;
    prev_done = 1'b0; post_busy = 1'b1;
    t = 0; widx = 0; gcnt = 0; fin = 0;
    while (!fin) begin
      start     = (t == 0);
      in_valid  = (gcnt == 0) && (widx < NW);
      in_data   = (widx < NW) ? words[widx] : '0;
      out_ready = !(t >= slo && t <= shi);
      R         = (t == rst_at);
      hsb = hs_t.size();
      cycle();
      if (hs_t.size() != hsb) begin
        widx++;
        gcnt = gap;
      end else if (gcnt > 0) begin
        gcnt--;
      end
      if (R) fin = 1;
      if (done_cnt > 0 && t > done_t + 1) fin = 1;
      if (!fin && t > 400) begin
        chk("session_done_seen", done_cnt, 1);
        fin = 1;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic session_checks(input logic [CL-1:0] init);
    chk("handshake_count", hs_t.size(), NW);
    chk("shift_count", nsh, CL);
    chk("shifted_bits", shifted, exp_load());
    chk("chain_after", chain, exp_load());
    chk("readback_count", rb_q.size(), NW);
    for (int k = 0; k < rb_q.size() && k < NW; k++) chk("readback_word", rb_q[k], exp_rb(init, k));
    chk("done_pulses", done_cnt, 1);
    chk("busy_after_done", post_busy, 0);
    chk("scan_en_si_rules", en_bad, 0);
    chk("done_after_last_readback", done_t > last_rb_t, 1);
  endtask

  initial begin
    logic [CL-1:0] init;
    int            early;
    logic          init2, shbit2, rb2, sh2, si2v;
    int            hs2, nsh2, nrb2, ndone2, late_busy2;

    chain = 10'h2AB;
    scan_so = chain[0];
    prev_si = 1'b0;
    R = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    R = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_scan_en", scan_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_scan_si", scan_si, 0);
    @(posedge clk);
    #1;

    // Session 1: directed timing and the known 0x2AB readback.
    sess = 1;
    words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'h3;
    run_session(0, -1, -1, -1, init);
    session_checks(init);
    if (hs_t.size() == 3) begin
      chk("hs_cycle0", hs_t[0], 1);
      chk("hs_cycle1", hs_t[1], 6);
      chk("hs_cycle2", hs_t[2], 11);
    end
    if (sh_t.size() == CL) begin
      chk("shift_first", sh_t[0], 2);
      chk("shift_w0_end", sh_t[3], 5);
      chk("shift_w1_start", sh_t[4], 7);
      chk("shift_last", sh_t[9], 13);
    end
    if (rb_q.size() == 3) begin
      chk("rb0_literal", rb_q[0], 4'hB);
      chk("rb1_literal", rb_q[1], 4'hA);
      chk("rb2_literal", rb_q[2], 4'h2);
    end
    chk("chain_literal", chain, 10'h35A);
    chk("done_not_early", done_t >= 14, 1);

    // Session 2: readback consumer stalled t3..t20.
    sess = 2;
    run_session(0, 3, 20, -1, init);
    session_checks(init);
    early = 0;
    foreach (sh_t[i]) if (sh_t[i] <= 20) early++;
    chk("shifts_during_stall", early, 8);

    // Session 3: 3-cycle gaps between load words.
    sess = 3;
    for (int i = 0; i < NW; i++) words[i] = W'($urandom);
    run_session(3, -1, -1, -1, init);
    session_checks(init);

    // Session 4: reset at t8 abandons the session.
    sess = 4;
    run_session(0, -1, -1, 8, init);
    R = 1'b0;
    prev_si = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_scan_en", scan_en, 0);
    chk("midrst_clk_en", scan_clk_en, 0);
    chk("midrst_scan_si", scan_si, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    @(posedge clk);
    #1;

    // Session 5 onward: fresh load after reset, then randomised sessions.
    for (int s = 0; s < 5; s++) begin
      int gap, slo;
      sess = 5 + s;
      for (int i = 0; i < NW; i++) words[i] = W'($urandom);
      gap = (s == 0) ? 0 : int'($urandom_range(0, 3));
      slo = (s == 0) ? -1 : int'($urandom_range(0, 15));
      run_session(gap, slo, slo + int'($urandom_range(0, 12)), -1, init);
      session_checks(init);
    end

    // Single-cell, single-bit instance with start re-pulsed while busy.
    sess = 20;
    init2 = 1'($urandom);
    so2 = init2;
    in_data2 = 1'($urandom);
    in_valid2 = 1'b1;
    out_ready2 = 1'b1;
    hs2 = 0; nsh2 = 0; nrb2 = 0; ndone2 = 0; late_busy2 = 0; shbit2 = 1'b0; rb2 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      start2 = (c == 0 || c == 3 || c == 4);
      @(negedge clk);
      sh2  = scan_clk_en2;
      si2v = scan_si2;
      if (in_valid2 && in_ready2) hs2++;
      if (sh2) begin
        nsh2++;
        shbit2 = si2v;
      end
      if (out_valid2 && out_ready2) begin
        nrb2++;
        rb2 = out_data2[0];
      end
      if (done2) ndone2++;
      if (c >= 6 && busy2) late_busy2++;
      @(posedge clk);
      #1;
      if (sh2) so2 = si2v;
    end
    start2 = 1'b0;
    chk("one_bit_handshakes", hs2, 1);
    chk("one_bit_shifts", nsh2, 1);
    chk("one_bit_readbacks", nrb2, 1);
    chk("one_bit_done", ndone2, 1);
    chk("one_bit_restart_ignored", late_busy2, 0);
    chk("one_bit_readback", rb2, init2);
    chk("one_bit_si", shbit2, in_data2);
    chk("one_bit_chain", so2, in_data2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
